// File: rtl/fifo_stream_pkg.sv
// Shared types and sizes for the FIFO read-side stream adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional build macro FIFO_RD_STREAM_STATS_EN sizes the beat counter with BEAT_CNT_W.
package fifo_stream_pkg;

   // Output buffer holds a head entry plus one skid entry
   localparam int SKID_DEPTH = 2;

   // Width of the optional accepted-beat counter
   localparam int BEAT_CNT_W = 16;

   // Encoding doubles as the number of valid entries (0/1/2)
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry head/skid register pair feeding a valid/ready stream.
// Latency: 1 cycle from i_push to o_vld when empty.
// Backpressure: holds head stable while !i_pop; caller must never push into a full pair without popping.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_push/i_push_dat new entry arriving this cycle
//   i_pop             head consumed this cycle (only meaningful while o_vld=1)
//   o_vld/o_dat       registered head entry
//   o_occ             current occupancy (EMPTY/ONE/TWO)
module stream_skid2
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_dat,
   input  logic                  i_pop,
   output logic                  o_vld,
   output logic [DATA_WIDTH-1:0] o_dat,
   output occ_e                  o_occ
);

   occ_e                  r_occ;
   logic                  r_vld;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_skid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_occ  <= OCC_EMPTY;
         r_vld  <= 1'b0;
         r_head <= '0;
         r_skid <= '0;
      end else begin
         case (r_occ)
            OCC_EMPTY: begin
               if (i_push) begin
                  r_head <= i_push_dat;
                  r_vld  <= 1'b1;
                  r_occ  <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (i_push && i_pop) begin
                  // Head leaves as the new beat arrives: bypass the skid
                  r_head <= i_push_dat;
               end else if (i_push) begin
                  r_skid <= i_push_dat;
                  r_occ  <= OCC_TWO;
               end else if (i_pop) begin
                  // Head value is left in place; o_vld masks it
                  r_vld  <= 1'b0;
                  r_occ  <= OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               if (i_pop) begin
                  r_head <= r_skid;
                  if (i_push) begin
                     r_skid <= i_push_dat;
                  end else begin
                     r_occ  <= OCC_ONE;
                  end
               end
            end
            default: begin
               r_vld <= 1'b0;
               r_occ <= OCC_EMPTY;
            end
         endcase
      end
   end

   assign o_vld = r_vld;
   assign o_dat = r_head;
   assign o_occ = r_occ;

   // The upstream issue rule must never return a beat into a full, stalled pair
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(i_push && !i_pop && (r_occ == OCC_TWO)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: turns a 1-cycle-latency FIFO read port into a valid/ready stream.
// Latency: m_valid rises 2 cycles after fifo_empty falls; 1 beat/cycle sustained with m_ready high.
// Backpressure: reads are only issued when a buffer slot is guaranteed for the returning beat.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fifo_empty/fifo_rd_en     FIFO status and combinational read request
//   fifo_rdata                FIFO data, valid the cycle after fifo_rd_en
//   m_valid/m_ready/m_data    registered output stream
//   beat_cnt                  saturating accepted-beat counter, present only with FIFO_RD_STREAM_STATS_EN
module fifo_rd_stream
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

   logic       r_inflight;
   logic       w_pop;
   occ_e       w_occ;
   logic [1:0] w_occ_cnt;
   logic [2:0] w_commit;
   logic [2:0] w_limit;

   assign w_pop     = m_valid & m_ready;
   assign w_occ_cnt = w_occ;

   // Slots already committed (held + returning) must stay below capacity once this
   // cycle's pop is credited back; the pop credit is what allows 1 beat/cycle.
   assign w_commit   = {1'b0, w_occ_cnt} + {2'b00, r_inflight};
   assign w_limit    = 3'(SKID_DEPTH) + {2'b00, w_pop};
   assign fifo_rd_en = !fifo_empty && !rst && (w_commit < w_limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= fifo_rd_en;
      end
   end

   stream_skid2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .i_push     (r_inflight),
      .i_push_dat (fifo_rdata),
      .i_pop      (w_pop),
      .o_vld      (m_valid),
      .o_dat      (m_data),
      .o_occ      (w_occ)
   );

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [BEAT_CNT_W-1:0] r_beat_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_cnt <= '0;
      end else if (w_pop && (r_beat_cnt != '1)) begin
         r_beat_cnt <= r_beat_cnt + 1'b1;
      end
   end

   assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a behavioural FIFO and a data scoreboard.
// Latency: n/a.
// Backpressure: m_ready driven from per-test patterns.
module tb_fifo_rd_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] fifo_rdata;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [15:0] beat_cnt;
`endif

   fifo_rd_stream #(.DATA_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data)
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .beat_cnt   (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];

   int cyc = 0;
   int base_cyc;
   int rd_pulses;
   int pops;
   int first_pop;
   int last_pop;
   int first_vld;

   logic       s_rd;
   logic       s_vld;
   logic [7:0] s_dat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic clr_stats();
      base_cyc  = cyc;
      rd_pulses = 0;
      pops      = 0;
      first_pop = -1;
      last_pop  = -1;
      first_vld = -1;
   endtask

   task automatic push_beat(input logic [7:0] d);
      fifo_q.push_back(d);
      exp_q.push_back(d);
      fifo_empty = 1'b0;
   endtask

   // One clock: sample outputs at negedge, then model the FIFO pop at the rising edge.
   task automatic tick();
      logic rd_now;
      @(negedge clk);
      rd_now = fifo_rd_en;
      s_rd   = fifo_rd_en;
      s_vld  = m_valid;
      s_dat  = m_data;
      if (rd_now) rd_pulses++;
      if (m_valid && first_vld < 0) first_vld = cyc - base_cyc;
      if (m_valid && m_ready) begin
         pops++;
         if (first_pop < 0) first_pop = cyc - base_cyc;
         last_pop = cyc - base_cyc;
         if (exp_q.size() == 0) chk("sb_unexpected_beat", exp_q.size(), 1);
         else                   chk("sb_data", m_data, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      if (rd_now) begin
         if (fifo_q.size() == 0) chk("fifo_underrun", fifo_q.size(), 1);
         else                    fifo_rdata = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
      cyc++;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   localparam logic [5:0] RDY_PAT = 6'b001101; // bit i = m_ready in step i: 1,0,1,1,0,0

   initial begin
      rst        = 1'b1;
      m_ready    = 1'b0;
      fifo_empty = 1'b1;
      fifo_rdata = 8'h5A;

      // Reset state
      tick();
      tick();
      chk("rst_rd_en", s_rd, 0);
      chk("rst_vld", s_vld, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_vld", s_vld, 0);
      chk("post_rst_dat", s_dat, 0);

      // Three beats, m_ready high
      m_ready = 1'b1;
      clr_stats();
      push_beat(8'h11);
      push_beat(8'h22);
      push_beat(8'h33);
      for (int i = 0; i < 8; i++) tick();
      chk("t1_first_vld_lat", first_vld, 2);
      chk("t1_rd_pulses", rd_pulses, 3);
      chk("t1_pops", pops, 3);
      chk("t1_consecutive", last_pop - first_pop, 2);

      // Five beats with consumer stalled
      m_ready = 1'b0;
      clr_stats();
      for (int i = 0; i < 5; i++) push_beat(8'hA0 + 8'(i));
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i >= 2) begin
            chk("t2_hold_vld", s_vld, 1);
            chk("t2_hold_dat", s_dat, 8'hA0);
         end
      end
      chk("t2_rd_pulses_stalled", rd_pulses, 2);
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("t2_pops", pops, 5);
      chk("t2_rd_pulses_total", rd_pulses, 5);
      chk("t2_no_gaps", last_pop - first_pop, 4);
      chk("t2_sb_drained", exp_q.size(), 0);

      // 16 incrementing bytes fed one per cycle, toggling m_ready
      clr_stats();
      begin
         int n = 0;
         for (int i = 0; i < 80; i++) begin
            if (n < 16) begin
               push_beat(8'(n));
               n++;
            end
            m_ready = RDY_PAT[i % 6];
            tick();
         end
      end
      chk("t3_pops", pops, 16);
      chk("t3_sb_drained", exp_q.size(), 0);

      // FIFO runs dry mid-stream
      m_ready = 1'b1;
      clr_stats();
      for (int i = 0; i < 3; i++) push_beat(8'hB0 + 8'(i));
      for (int i = 0; i < 3; i++) tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t4_no_rd_when_empty", s_rd, 0);
      end
      chk("t4_drained_vld", s_vld, 0);
      chk("t4_pops_before_gap", pops, 3);
      for (int i = 0; i < 3; i++) push_beat(8'hC0 + 8'(i));
      for (int i = 0; i < 8; i++) tick();
      chk("t4_pops_total", pops, 6);
      chk("t4_sb_drained", exp_q.size(), 0);

      // Reset while a head is held and a read is in flight
      m_ready = 1'b0;
      clr_stats();
      for (int i = 0; i < 4; i++) push_beat(8'hD0 + 8'(i));
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("t5_rd_en_in_rst", s_rd, 0);
      rst = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      fifo_empty = 1'b1;
      fifo_rdata = 8'hEE;
      tick();
      chk("t5_vld_after_rst", s_vld, 0);
      chk("t5_dat_after_rst", s_dat, 0);
      chk("t5_rd_after_rst", s_rd, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_no_stale_capture", s_vld, 0);
      end
      m_ready = 1'b1;
      clr_stats();
      push_beat(8'hE1);
      push_beat(8'hE2);
      for (int i = 0; i < 6; i++) tick();
      chk("t5_recover_pops", pops, 2);

`ifdef FIFO_RD_STREAM_STATS_EN
      // Saturation of the accepted-beat counter
      for (int i = 0; i < 71000 && pops < 70000; i++) begin
         if (fifo_q.size() < 2) push_beat(8'(i));
         tick();
      end
      chk("stat_pops_reached", (pops >= 70000) ? 1 : 0, 1);
      chk("stat_beat_cnt_sat", beat_cnt, 16'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
